// File: rtl/packet_detect_ctrl_pkg.sv
// rtl/packet_detect_ctrl_pkg.sv - shared OFDM receive definitions for packet detection
package packet_detect_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_WARMUP  = 3'd2,
    ST_SEARCH  = 3'd3,
    ST_CONFIRM = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_HOLDOFF = 3'd6
  } pd_state_e;

  localparam int unsigned METRIC_W       = 21;
  localparam int unsigned CMP_W          = 23;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned WARMUP_METRICS = 16;

  localparam int unsigned         DEF_HIT_COUNT  = 16;
  localparam logic [METRIC_W-1:0] DEF_ENERGY_MIN = 21'h00400;
  localparam int unsigned         DEF_HOLDOFF    = 32;

  // Correlation must reach THR_NUM/THR_DEN of the energy to count as a hit.
  localparam int unsigned THR_NUM = 3;
  localparam int unsigned THR_DEN = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/packet_detect_ctrl_cmp.sv
// rtl/packet_detect_ctrl_cmp.sv - combinational hit comparator for the detection metric
module detect_metric_cmp
  import packet_detect_ctrl_pkg::*;
#(
  parameter logic [METRIC_W-1:0] ENERGY_MIN = DEF_ENERGY_MIN
) (
  input  logic                i_metric_valid,
  input  logic [METRIC_W-1:0] i_energy,
  input  logic [METRIC_W-1:0] i_corr,
  output logic                o_hit
);

  logic [CMP_W-1:0] w_corr_scaled;
  logic [CMP_W-1:0] w_energy_scaled;

  // Widened to 23 bits so neither product can overflow.
  assign w_corr_scaled   = CMP_W'(i_corr) * CMP_W'(THR_DEN);
  assign w_energy_scaled = CMP_W'(i_energy) * CMP_W'(THR_NUM);

  assign o_hit = i_metric_valid
               && (i_energy >= ENERGY_MIN)
               && (w_corr_scaled >= w_energy_scaled);

endmodule

// File: rtl/packet_detect_ctrl.sv
// rtl/packet_detect_ctrl.sv - packet detection FSM with shared frame/holdoff counter
module packet_detect_ctrl
  import packet_detect_ctrl_pkg::*;
#(
  parameter int unsigned         HIT_COUNT  = DEF_HIT_COUNT,
  parameter logic [METRIC_W-1:0] ENERGY_MIN = DEF_ENERGY_MIN,
  parameter int unsigned         HOLDOFF    = DEF_HOLDOFF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_sample_enable,
  input  logic                i_metric_valid,
  input  logic [METRIC_W-1:0] i_energy,
  input  logic [METRIC_W-1:0] i_corr,
  input  logic [LEN_W-1:0]    i_frame_len,
  output logic                o_accum_in_enable,
  output logic                o_packet_detect,
  output logic                o_locked,
  output logic                o_frame_done,
  output logic [2:0]          o_state
);

  localparam logic [CNT_W-1:0] HIT_TARGET = CNT_W'(HIT_COUNT);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_METRICS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  pd_state_e        r_state;
  pd_state_e        w_state_nxt;
  logic             r_gate;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             r_pd;
  logic             w_pd_nxt;
  logic             r_fd;
  logic             w_fd_nxt;
  logic             w_hit;
  logic             w_lock;

  detect_metric_cmp #(
    .ENERGY_MIN(ENERGY_MIN)
  ) u_cmp (
    .i_metric_valid(i_metric_valid),
    .i_energy      (i_energy),
    .i_corr        (i_corr),
    .o_hit         (w_hit)
  );

  assign w_cnt_inc = sat_inc(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_pd_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_lock      = 1'b0;

    // Dropping start wins over every other transition and suppresses pulses.
    if ((r_state != ST_IDLE) && !i_start) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = '0;
          end
        end
        ST_FLUSH: begin
          w_state_nxt = ST_WARMUP;
          w_cnt_nxt   = '0;
        end
        ST_WARMUP: begin
          if (i_metric_valid) begin
            if (r_cnt >= WARM_LAST) begin
              w_state_nxt = ST_SEARCH;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        ST_SEARCH: begin
          if (w_hit) begin
            if (HIT_TARGET <= 16'd1) begin
              w_lock = 1'b1;
            end else begin
              w_state_nxt = ST_CONFIRM;
              w_cnt_nxt   = 16'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (i_metric_valid) begin
            if (w_hit) begin
              if (w_cnt_inc >= HIT_TARGET) begin
                w_lock = 1'b1;
              end else begin
                w_cnt_nxt = w_cnt_inc;
              end
            end else begin
              w_state_nxt = ST_SEARCH;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (i_sample_enable) begin
            if (r_cnt >= (r_len - 16'd1)) begin
              w_fd_nxt    = 1'b1;
              w_state_nxt = ST_HOLDOFF;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt >= HOLD_LAST) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase

      // A zero frame length would never terminate, so it is treated as one sample.
      if (w_lock) begin
        w_state_nxt = ST_LOCKED;
        w_pd_nxt    = 1'b1;
        w_cnt_nxt   = '0;
        w_len_nxt   = (i_frame_len == '0) ? 16'd1 : i_frame_len;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gate  <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_pd    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gate  <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FLUSH);
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_pd    <= w_pd_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign o_accum_in_enable = i_sample_enable & r_gate;
  assign o_packet_detect   = r_pd;
  assign o_frame_done      = r_fd;
  assign o_locked          = (r_state == ST_LOCKED);
  assign o_state           = r_state;

endmodule

// File: tb/tb_packet_detect_ctrl.sv
// tb/tb_packet_detect_ctrl.sv - self-checking bench for packet_detect_ctrl
module tb_packet_detect_ctrl;

  localparam int HC   = 16;
  localparam int EMIN = 'h400;
  localparam int HO   = 32;
  localparam int WARM = 16;
  localparam int E_HIT = 'h01000;
  localparam int C_HIT = 'h00C00;

  localparam int P_IDLE = 0, P_FLUSH = 1, P_WARMUP = 2, P_SEARCH = 3;
  localparam int P_CONFIRM = 4, P_LOCKED = 5, P_HOLDOFF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        se = 1'b1;
  logic        mv = 1'b0;
  logic [20:0] energy = '0;
  logic [20:0] corr = '0;
  logic [15:0] frame_len = '0;
  logic        accum, pd, locked, fd;
  logic [2:0]  state;

  int n_vec = 0;
  int n_fail = 0;
  int pd_seen = 0;
  int fd_seen = 0;

  int m_phase = P_IDLE;
  int m_warm_left = 0, m_streak = 0, m_frame_left = 0, m_hold_left = 0;
  int m_pd = 0, m_fd = 0;

  always #5 clk = ~clk;

  packet_detect_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_sample_enable  (se),
    .i_metric_valid   (mv),
    .i_energy         (energy),
    .i_corr           (corr),
    .i_frame_len      (frame_len),
    .o_accum_in_enable(accum),
    .o_packet_detect  (pd),
    .o_locked         (locked),
    .o_frame_done     (fd),
    .o_state          (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_pd = 0;
    m_fd = 0;
  endtask

  // Countdown-based reference: what each clock edge must produce from the rules.
  task automatic model_step(input bit st, input bit s, input bit m, input int e, input int c, input int fl);
    bit hit;
    hit = m && (e >= EMIN) && (4 * c >= 3 * e);
    m_pd = 0;
    m_fd = 0;
    if (m_phase != P_IDLE && !st) begin
      m_phase = P_IDLE;
    end else if (m_phase == P_IDLE) begin
      if (st) m_phase = P_FLUSH;
    end else if (m_phase == P_FLUSH) begin
      m_phase = P_WARMUP;
      m_warm_left = WARM;
    end else if (m_phase == P_WARMUP) begin
      if (m) begin
        m_warm_left--;
        if (m_warm_left == 0) m_phase = P_SEARCH;
      end
    end else if (m_phase == P_SEARCH || m_phase == P_CONFIRM) begin
      if (hit) begin
        m_streak = (m_phase == P_SEARCH) ? 1 : m_streak + 1;
        if (m_streak >= HC) begin
          m_phase = P_LOCKED;
          m_pd = 1;
          m_frame_left = (fl == 0) ? 1 : fl;
        end else begin
          m_phase = P_CONFIRM;
        end
      end else if (m) begin
        m_phase = P_SEARCH;
      end
    end else if (m_phase == P_LOCKED) begin
      if (s) begin
        m_frame_left--;
        if (m_frame_left == 0) begin
          m_fd = 1;
          m_phase = P_HOLDOFF;
          m_hold_left = HO;
        end
      end
    end else if (m_phase == P_HOLDOFF) begin
      m_hold_left--;
      if (m_hold_left == 0) m_phase = P_FLUSH;
    end
  endtask

  always begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(start, se, mv, int'(energy), int'(corr), int'(frame_len));
    #1;
    chk("state", int'(state), m_phase);
    chk("packet_detect", int'(pd), m_pd);
    chk("frame_done", int'(fd), m_fd);
    chk("locked", int'(locked), int'(m_phase == P_LOCKED));
    chk("accum_in_enable", int'(accum), int'(se && (m_phase > P_FLUSH)));
  end

  task automatic step(input bit st, input bit s, input bit m, input int e, input int c, input int fl);
    @(negedge clk);
    start = st;
    se = s;
    mv = m;
    energy = 21'(e);
    corr = 21'(c);
    frame_len = 16'(fl);
    @(posedge clk);
    #2;
    pd_seen += int'(pd);
    fd_seen += int'(fd);
  endtask

  task automatic metrics(input int n, input int fl);
    for (int i = 0; i < n; i++) step(1, 1, 1, E_HIT, C_HIT, fl);
  endtask

  int hold_cycles;
  int r;
  int e_r;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_accum", int'(accum), 0);
    chk("rst_pd", int'(pd), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fd", int'(fd), 0);

    step(1, 1, 0, 0, 0, 0);
    chk("flush_state", int'(state), 1);
    chk("flush_accum", int'(accum), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("warmup_state", int'(state), 2);
    chk("warmup_accum", int'(accum), 1);
    metrics(15, 100);
    chk("warmup_15", int'(state), 2);
    metrics(1, 100);
    chk("warmup_16", int'(state), 3);

    pd_seen = 0;
    metrics(15, 100);
    chk("confirm_15", int'(state), 4);
    step(1, 1, 1, E_HIT, 'h00BFF, 100);
    chk("near_miss_state", int'(state), 3);
    chk("near_miss_no_pd", pd_seen, 0);

    pd_seen = 0;
    metrics(16, 100);
    chk("lock_state", int'(state), 5);
    chk("lock_locked", int'(locked), 1);
    chk("lock_pd", int'(pd), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("pd_once", pd_seen, 1);
    fd_seen = 0;
    for (int i = 0; i < 98; i++) step(1, 1, 0, 0, 0, 0);
    chk("fd_not_early", fd_seen, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("fd_at_100", int'(fd), 1);
    chk("holdoff_state", int'(state), 6);
    hold_cycles = 1;
    for (int i = 0; i < 40 && state == 3'd6; i++) begin
      step(1, 1, 0, 0, 0, 0);
      if (state == 3'd6) hold_cycles++;
    end
    chk("holdoff_len", hold_cycles, 32);
    chk("after_holdoff", int'(state), 1);

    step(1, 1, 0, 0, 0, 0);
    metrics(16, 100);
    metrics(16, 100);
    chk("relock_state", int'(state), 5);
    fd_seen = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("abort_state", int'(state), 0);
    chk("abort_accum", int'(accum), 0);
    chk("abort_no_fd", fd_seen, 0);

    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    metrics(16, 100);
    step(1, 1, 1, 'h003FF, 'h003FF, 100);
    chk("low_energy_no_hit", int'(state), 3);
    metrics(5, 100);
    chk("mid_confirm", int'(state), 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_accum", int'(accum), 0);
    chk("async_rst_pd", int'(pd), 0);
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_fd", int'(fd), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_state", int'(state), 0);

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 2999) != 0);
      start = ($urandom_range(0, 299) != 0);
      se = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 2) != 0);
      frame_len = 16'($urandom_range(0, 40));
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        e_r = (r < 2) ? EMIN - 1 : EMIN;
        energy = 21'(e_r);
        corr = 21'(e_r);
      end else if (r < 10) begin
        e_r = int'($urandom_range(32'h100, 32'h7FFFF)) * 4;
        energy = 21'(e_r);
        corr = 21'((e_r / 4) * 3 - ((r < 7) ? 1 : 0));
      end else if (r < 92) begin
        e_r = int'($urandom_range(32'h400, 32'h1FFFFF));
        energy = 21'(e_r);
        corr = 21'(e_r - int'($urandom_range(0, e_r / 4)));
      end else begin
        energy = 21'($urandom);
        corr = 21'($urandom);
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
